prog_adr_redirect: RTL and testbench
====================================

Name: prog_adr_redirect

Overview:
Parametrised successor to the pass-through program-address stage between the PC register and the program-memory address bus. It watches the opcode field of each fetched instruction for a configurable in-order opcode sequence. On a full match it adds a fixed offset to the outgoing address for a bounded number of fetches, then returns to pass-through. With TRIG_ENABLE=0 it is exactly the clean pass-through.

Parameters:
ADDR_W, 13, program address width (pc_reg, prog_adr_o)
INSTR_W, 14, instruction word width
OPC_W, 4, opcode field width; opcode = prog_dat_i[INSTR_W-1 -: OPC_W]
SEQ_LEN, 4, number of opcodes in the trigger sequence (1..8)
PATTERN, 16'hBA98, packed sequence; element i = PATTERN[OPC_W*i +: OPC_W]; element 0 matched first (default 8,9,A,B)
PC_OFFSET, 2, offset added to pc_reg while active (ADDR_W bits)
HOLD_FETCHES, 8, valid fetches the offset stays applied; 0 = stay active until reset
TRIG_ENABLE, 1, 0 = FSM held in IDLE, pure pass-through

Ports:
clk  input  1  system clock, rising edge
pon_rst_n_i  input  1  power-on reset, asynchronous, active-low
fetch_valid_i  input  1  prog_dat_i holds a newly fetched instruction this cycle
prog_dat_i  input  INSTR_W  fetched instruction word
pc_reg  input  ADDR_W  current program counter
prog_adr_o  output  ADDR_W  program-memory address
active_o  output  1  registered; 1 while offset applied
seq_idx_o  output  3  registered; current match index (debug)

Behaviour:
- Reset (pon_rst_n_i low, asynchronous): state=IDLE, seq_idx=0, hold_cnt=0, active_o=0, seq_idx_o=0, so prog_adr_o=pc_reg. Takes effect immediately, including mid-match or mid-ACTIVE.
- States: IDLE (seq_idx=0), MATCH (0<seq_idx<SEQ_LEN), ACTIVE.
- Cycles with fetch_valid_i=0 never change state, index or counter. Gaps between matching fetches do not break a sequence.
- IDLE/MATCH, on a valid fetch:
  - If the opcode equals PATTERN[seq_idx]: seq_idx+1.
  - If that completes SEQ_LEN: go to ACTIVE, seq_idx=0, hold_cnt=HOLD_FETCHES.
  - On mismatch: if the opcode equals element 0, seq_idx=1; else seq_idx=0. This is a restart-on-first-element overlap rule, not full KMP.
  - SEQ_LEN=1: a single matching fetch enters ACTIVE.
- Latency: active_o and the offset take effect in the cycle after the clock edge that samples the final matching fetch.
- ACTIVE:
  - prog_adr_o = (pc_reg + PC_OFFSET) mod 2^ADDR_W, combinational from pc_reg and the registered state; the carry is discarded (wrap-around).
  - Each valid fetch decrements hold_cnt. The fetch that takes it from 1 to 0 returns the FSM to IDLE at that edge, so exactly HOLD_FETCHES valid fetches are offset.
  - HOLD_FETCHES=0: no decrement; ACTIVE until reset.
  - Opcode matching is suspended; opcodes seen during ACTIVE do not count toward the next trigger.
- Not ACTIVE: prog_adr_o = pc_reg exactly, combinational, zero latency.
- TRIG_ENABLE=0: state is held in IDLE, active_o=0 and seq_idx_o=0 forever.
- seq_idx_o is zero-extended; SEQ_LEN > 8 is illegal (elaboration error).
- No X propagation from prog_dat_i when fetch_valid_i=0: the opcode is not sampled.

Test Plan:
- Defaults; pc_reg=0x0100; valid fetches with opcodes 8,9,A,B, then 8 more valid fetches -> active_o=1 from the cycle after the B fetch; prog_adr_o=0x0102 for exactly 8 valid fetches; then active_o=0 and prog_adr_o=0x0100.
- Opcodes 8,8,9,A,B with fetch_valid_i deasserted 3 cycles between A and B -> trigger fires after B; seq_idx_o sequence 1,1,2,3,(ACTIVE).
- Opcodes 8,9,C,A,B -> no trigger; seq_idx_o returns to 0 at C; prog_adr_o==pc_reg throughout.
- ACTIVE with pc_reg=0x1FFF -> prog_adr_o=0x0001 (13-bit wrap).
- pon_rst_n_i pulsed low mid-ACTIVE (after 3 offset fetches), asynchronous to clk -> active_o=0 and prog_adr_o=pc_reg immediately; a full sequence is needed to re-trigger.
- TRIG_ENABLE=0, apply 8,9,A,B repeatedly; HOLD_FETCHES=0 build with one trigger plus 100 fetches -> first: prog_adr_o always equals pc_reg; second: offset persists for all 100 fetches.

Source files
------------

// File: rtl/prog_adr_redirect_if.sv
// Program-address stage bus: fetch side inputs and redirected address outputs.
// The master drives fetches and the PC; the slave returns address and status.
interface prog_adr_redirect_if #(
    parameter int ADDR_W  = 13,
    parameter int INSTR_W = 14
);
    logic               fetch_valid_i;
    logic [INSTR_W-1:0] prog_dat_i;
    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  prog_adr_o;
    logic               active_o;
    logic [2:0]         seq_idx_o;

    modport master (
        output fetch_valid_i, prog_dat_i, pc_reg,
        input  prog_adr_o, active_o, seq_idx_o
    );

    modport slave (
        input  fetch_valid_i, prog_dat_i, pc_reg,
        output prog_adr_o, active_o, seq_idx_o
    );
endinterface

// File: rtl/prog_adr_redirect.sv
// Program-address stage: pass-through PC, offset for a bounded number of
// fetches after a configured opcode sequence is observed.
module prog_adr_redirect #(
    parameter int ADDR_W       = 13,
    parameter int INSTR_W      = 14,
    parameter int OPC_W        = 4,
    parameter int SEQ_LEN      = 4,
    parameter logic [OPC_W*SEQ_LEN-1:0] PATTERN = 16'hBA98,
    parameter int PC_OFFSET    = 2,
    parameter int HOLD_FETCHES = 8,
    parameter bit TRIG_ENABLE  = 1'b1
) (
    input  logic clk,
    input  logic pon_rst_n_i,
    prog_adr_redirect_if.slave bus
);
    if (SEQ_LEN < 1 || SEQ_LEN > 8) begin : g_bad_seq_len
        $error("prog_adr_redirect: SEQ_LEN must be 1..8");
    end

    localparam int HCW = (HOLD_FETCHES < 2) ? 1 : $clog2(HOLD_FETCHES + 1);
    // Pad the pattern to eight slots so any 3-bit index selects in range.
    localparam logic [OPC_W*8-1:0] PAT_EXT = (OPC_W*8)'(PATTERN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MATCH  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     seq_idx_q, seq_idx_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

    logic [OPC_W-1:0] opc;
    logic [OPC_W-1:0] pat_cur;
    logic [OPC_W-1:0] pat_first;

    assign opc       = bus.prog_dat_i[INSTR_W-1 -: OPC_W];
    assign pat_cur   = PAT_EXT[OPC_W*seq_idx_q +: OPC_W];
    assign pat_first = PAT_EXT[OPC_W-1:0];

    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            state_q    <= IDLE;
            seq_idx_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seq_idx_q  <= seq_idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_idx_d  = seq_idx_q;
        hold_cnt_d = hold_cnt_q;
        if (!TRIG_ENABLE) begin
            state_d    = IDLE;
            seq_idx_d  = '0;
            hold_cnt_d = '0;
        end else if (bus.fetch_valid_i) begin
            unique case (state_q)
                IDLE, MATCH: begin
                    if (opc == pat_cur) begin
                        if (seq_idx_q == 3'(SEQ_LEN - 1)) begin
                            state_d    = ACTIVE;
                            seq_idx_d  = '0;
                            hold_cnt_d = HCW'(HOLD_FETCHES);
                        end else begin
                            state_d   = MATCH;
                            seq_idx_d = seq_idx_q + 3'd1;
                        end
                    end else if (opc == pat_first) begin
                        // Restart on the first element only; no deeper overlap.
                        state_d   = MATCH;
                        seq_idx_d = 3'd1;
                    end else begin
                        state_d   = IDLE;
                        seq_idx_d = '0;
                    end
                end
                ACTIVE: begin
                    if (HOLD_FETCHES != 0) begin
                        if (hold_cnt_q == HCW'(1)) begin
                            state_d    = IDLE;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q - HCW'(1);
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    seq_idx_d  = '0;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.active_o   = (state_q == ACTIVE);
        bus.seq_idx_o  = seq_idx_q;
        bus.prog_adr_o = bus.pc_reg;
        if (state_q == ACTIVE) begin
            bus.prog_adr_o = bus.pc_reg + ADDR_W'(PC_OFFSET);
        end
    end
endmodule

// File: tb/tb_prog_adr_redirect.sv
// Directed bench: default build, a trigger-disabled build and a
// hold-forever build, all fed the same fetch stream.
module tb_prog_adr_redirect;
    logic        clk;
    logic        rst_n;
    logic        fv;
    logic [13:0] dat;
    logic [12:0] pc;

    int errors;
    int checks;

    prog_adr_redirect_if #(.ADDR_W(13), .INSTR_W(14)) b0 ();
    prog_adr_redirect_if #(.ADDR_W(13), .INSTR_W(14)) b1 ();
    prog_adr_redirect_if #(.ADDR_W(13), .INSTR_W(14)) b2 ();

    assign b0.fetch_valid_i = fv;
    assign b0.prog_dat_i    = dat;
    assign b0.pc_reg        = pc;
    assign b1.fetch_valid_i = fv;
    assign b1.prog_dat_i    = dat;
    assign b1.pc_reg        = pc;
    assign b2.fetch_valid_i = fv;
    assign b2.prog_dat_i    = dat;
    assign b2.pc_reg        = pc;

    prog_adr_redirect u_def (
        .clk         (clk),
        .pon_rst_n_i (rst_n),
        .bus         (b0)
    );

    prog_adr_redirect #(.TRIG_ENABLE(1'b0)) u_off (
        .clk         (clk),
        .pon_rst_n_i (rst_n),
        .bus         (b1)
    );

    prog_adr_redirect #(.HOLD_FETCHES(0)) u_hold (
        .clk         (clk),
        .pon_rst_n_i (rst_n),
        .bus         (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns after the rising edge.
    task automatic fetch(input bit v, input logic [3:0] opc);
        @(negedge clk);
        fv  = v;
        dat = v ? {opc, 10'h2A5} : 14'bx;
        @(posedge clk);
        #1;
        chk("off_adr", 32'(b1.prog_adr_o), 32'(pc));
        chk("off_act", 32'(b1.active_o), 32'd0);
        chk("off_idx", 32'(b1.seq_idx_o), 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        fv     = 1'b0;
        dat    = '0;
        pc     = 13'h0100;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_act", 32'(b0.active_o), 32'd0);
        chk("rst_idx", 32'(b0.seq_idx_o), 32'd0);
        chk("rst_adr", 32'(b0.prog_adr_o), 32'h0100);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic trigger and 8-fetch hold; ACTIVE opcodes must not count.
        fetch(1, 4'h8); chk("t1_idx1", 32'(b0.seq_idx_o), 32'd1);
        fetch(1, 4'h9); chk("t1_idx2", 32'(b0.seq_idx_o), 32'd2);
        fetch(1, 4'hA); chk("t1_idx3", 32'(b0.seq_idx_o), 32'd3);
        chk("t1_pre_act", 32'(b0.active_o), 32'd0);
        fetch(1, 4'hB);
        for (int i = 0; i < 8; i++) begin
            chk("t1_act", 32'(b0.active_o), 32'd1);
            chk("t1_adr", 32'(b0.prog_adr_o), 32'h0102);
            fetch(1, 4'(4'h8 + 4'(i % 4)));
            if (i < 7) fetch(0, 4'h0);
        end
        chk("t1_end_act", 32'(b0.active_o), 32'd0);
        chk("t1_end_adr", 32'(b0.prog_adr_o), 32'h0100);
        chk("t1_end_idx", 32'(b0.seq_idx_o), 32'd0);

        // Overlap restart plus a gap before the final element.
        fetch(1, 4'h8); chk("t2_idx_a", 32'(b0.seq_idx_o), 32'd1);
        fetch(1, 4'h8); chk("t2_idx_b", 32'(b0.seq_idx_o), 32'd1);
        fetch(1, 4'h9); chk("t2_idx_c", 32'(b0.seq_idx_o), 32'd2);
        fetch(1, 4'hA); chk("t2_idx_d", 32'(b0.seq_idx_o), 32'd3);
        repeat (3) fetch(0, 4'h0);
        chk("t2_gap_idx", 32'(b0.seq_idx_o), 32'd3);
        chk("t2_gap_act", 32'(b0.active_o), 32'd0);
        fetch(1, 4'hB);
        chk("t2_act", 32'(b0.active_o), 32'd1);
        chk("t2_adr", 32'(b0.prog_adr_o), 32'h0102);

        // 13-bit wrap while active.
        pc = 13'h1FFF;
        #1;
        chk("t4_wrap", 32'(b0.prog_adr_o), 32'h0001);
        repeat (8) fetch(1, 4'h0);
        chk("t4_exit_act", 32'(b0.active_o), 32'd0);
        chk("t4_exit_adr", 32'(b0.prog_adr_o), 32'h1FFF);
        pc = 13'h0100;

        // Broken sequence never triggers.
        fetch(1, 4'h8); chk("t3_idx_a", 32'(b0.seq_idx_o), 32'd1);
        fetch(1, 4'h9); chk("t3_idx_b", 32'(b0.seq_idx_o), 32'd2);
        fetch(1, 4'hC); chk("t3_idx_c", 32'(b0.seq_idx_o), 32'd0);
        fetch(1, 4'hA); chk("t3_idx_d", 32'(b0.seq_idx_o), 32'd0);
        fetch(1, 4'hB); chk("t3_idx_e", 32'(b0.seq_idx_o), 32'd0);
        chk("t3_act", 32'(b0.active_o), 32'd0);
        chk("t3_adr", 32'(b0.prog_adr_o), 32'h0100);

        // Asynchronous reset in the middle of ACTIVE.
        fetch(1, 4'h8);
        fetch(1, 4'h9);
        fetch(1, 4'hA);
        fetch(1, 4'hB);
        repeat (3) fetch(1, 4'h0);
        chk("t5_pre_act", 32'(b0.active_o), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_act", 32'(b0.active_o), 32'd0);
        chk("t5_rst_adr", 32'(b0.prog_adr_o), 32'h0100);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(1, 4'hB);
        chk("t5_b_act", 32'(b0.active_o), 32'd0);
        chk("t5_b_idx", 32'(b0.seq_idx_o), 32'd0);
        fetch(1, 4'h8);
        fetch(1, 4'h9);
        fetch(1, 4'hA);
        fetch(1, 4'hB);
        chk("t5_retrig", 32'(b0.active_o), 32'd1);

        // Hold-forever build: one trigger then 100 offset fetches.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_act", 32'(b2.active_o), 32'd0);
        fetch(1, 4'h8);
        fetch(1, 4'h9);
        fetch(1, 4'hA);
        fetch(1, 4'hB);
        for (int i = 0; i < 100; i++) begin
            pc = 13'h0100 + 13'(i);
            #1;
            chk("t6_act", 32'(b2.active_o), 32'd1);
            chk("t6_adr", 32'(b2.prog_adr_o), 32'(13'h0102 + 13'(i)));
            fetch(1, 4'(i));
        end
        chk("t6_end_act", 32'(b2.active_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
